// File: rtl/irq_conditioner.sv
// Interrupt conditioner: per-line synchroniser, level/sticky-edge capture, enable mask, Wishbone status/clear.
// Latency: raw line change reaches irq_o SYNC_STAGES+1 edges after it is sampled; bus ack one cycle after strobe.
// Backpressure: none; classic Wishbone, one ack per access, back-to-back accesses ack every other cycle.
module irq_conditioner #(
    parameter int          NUM_IRQ     = 32,
    parameter logic [31:0] EDGE_MASK   = 32'h0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic [NUM_IRQ-1:0] irq_src_i,
    input  logic [3:0]         wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    input  logic [3:0]         wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    output logic [NUM_IRQ-1:0] irq_o
);

    localparam logic [NUM_IRQ-1:0] EDGE = EDGE_MASK[NUM_IRQ-1:0];

    localparam logic [1:0] ADR_RAW     = 2'b00;
    localparam logic [1:0] ADR_PENDING = 2'b01;
    localparam logic [1:0] ADR_ENABLE  = 2'b10;
    localparam logic [1:0] ADR_ACTIVE  = 2'b11;

    // Synchroniser chain: index 0 samples the raw line, last index is the usable value.
    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
    logic [NUM_IRQ-1:0] s;
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [NUM_IRQ-1:0] irq_q;
    logic               ack_q;
    logic [31:0]        dat_q, dat_d;

    logic               access;
    logic               wr;
    logic [31:0]        wmask;
    logic [31:0]        wbits32;
    logic [NUM_IRQ-1:0] wbits;
    logic [NUM_IRQ-1:0] wmask_n;
    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] rise;

    // Address bits [1:0] are byte offsets within a word and never decoded.
    logic unused_bits;
    assign unused_bits = ^{wb_adr_i[1:0], wbits32, wmask};

    assign s       = sync_q[SYNC_STAGES-1];
    assign access  = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr      = access & wb_we_i;
    assign wmask   = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign wbits32 = wb_dat_i & wmask;
    assign wbits   = wbits32[NUM_IRQ-1:0];
    assign wmask_n = wmask[NUM_IRQ-1:0];
    assign rise    = s & ~prev_q;

    // Next-state for pending/enable: a fresh rising edge beats a simultaneous W1C.
    always_comb begin
        clr      = '0;
        enable_d = enable_q;
        if (wr && (wb_adr_i[3:2] == ADR_PENDING)) begin
            clr = wbits;
        end
        if (wr && (wb_adr_i[3:2] == ADR_ENABLE)) begin
            enable_d = (enable_q & ~wmask_n) | wbits;
        end
        pending_d = (EDGE & (rise | (pending_q & ~clr))) | (~EDGE & s);
    end

    // Read mux; values are pre-write so a write returns the old register contents.
    always_comb begin
        dat_d = '0;
        case (wb_adr_i[3:2])
            ADR_RAW:     dat_d[NUM_IRQ-1:0] = s;
            ADR_PENDING: dat_d[NUM_IRQ-1:0] = pending_q;
            ADR_ENABLE:  dat_d[NUM_IRQ-1:0] = enable_q;
            ADR_ACTIVE:  dat_d[NUM_IRQ-1:0] = pending_q & enable_q;
            default:     dat_d = '0;
        endcase
    end

    // All state; reset clears everything including any in-flight bus access.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync_q    <= '0;
            prev_q    <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            irq_q     <= '0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], irq_src_i};
            prev_q    <= s;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            irq_q     <= pending_q & enable_q;
            ack_q     <= access;
            if (access) begin
                dat_q <= dat_d;
            end
        end
    end

    assign irq_o    = irq_q;
    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_irq_conditioner.sv
// Directed bench for irq_conditioner: timing sequences plus a table of register-access vectors.
// Line 5 is sticky-edge, all other lines are level.
module tb_irq_conditioner;

    logic        clk;
    logic        rst_n;
    logic [31:0] src;
    logic [3:0]  adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [31:0] rdat;
    logic        ack;
    logic [31:0] irq;

    int tests;
    int failed;

    irq_conditioner #(
        .NUM_IRQ    (32),
        .EDGE_MASK  (32'h0000_0020),
        .SYNC_STAGES(2)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .irq_src_i(src),
        .wb_adr_i (adr),
        .wb_dat_i (wdat),
        .wb_sel_i (sel),
        .wb_we_i  (we),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_dat_o (rdat),
        .wb_ack_o (ack),
        .irq_o    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // One bus access; returns read data captured with the ack.
    task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] r);
        logic got;
        got  = 1'b0;
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = w;
        adr  = a;
        wdat = d;
        sel  = s;
        for (int i = 0; i < 4 && !got; i++) begin
            tick();
            if (ack) got = 1'b1;
        end
        r   = rdat;
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        check("bus_ack", {31'd0, got}, 32'd1);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        bus(1'b1, a, d, s, dummy);
    endtask

    task automatic rd_check(input string nm, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus(1'b0, a, 32'h0, 4'hF, r);
        check(nm, r, exp);
    endtask

    initial begin
        tests = 0;
        failed = 0;
        rst_n = 1'b0;
        src  = '0;
        adr  = '0;
        wdat = '0;
        sel  = '0;
        we   = 1'b0;
        cyc  = 1'b0;
        stb  = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_irq", irq, 32'h0);
        check("rst_ack", {31'd0, ack}, 32'h0);
        check("rst_dat", rdat, 32'h0);
        rst_n = 1'b1;
        tick();
        rd_check("rst_enable", 4'h8, 32'h0);

        // Level line 3: exactly three edges from sample to irq_o, both directions
        wr(4'h8, 32'hFFFF_FFFF, 4'hF);
        src[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("lvl_rise_e%0d", k), {31'd0, irq[3]}, {31'd0, k == 3});
        end
        src[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("lvl_fall_e%0d", k), {31'd0, irq[3]}, {31'd0, k != 3});
        end

        // Sticky edge on line 5, cleared by W1C
        src[5] = 1'b1;
        tick();
        tick();
        src[5] = 1'b0;
        repeat (5) tick();
        rd_check("edge_pending", 4'h4, 32'h20);
        check("edge_irq", irq, 32'h20);
        wr(4'h4, 32'h20, 4'hF);
        check("w1c_irq_same", irq, 32'h20);
        tick();
        check("w1c_irq_next", irq, 32'h0);
        rd_check("w1c_pending", 4'h4, 32'h0);

        // Rising edge lands on the same edge as its W1C: set wins
        src[5] = 1'b1;
        tick();
        tick();
        wr(4'h4, 32'h20, 4'hF);
        rd_check("collide_pending", 4'h4, 32'h20);
        src[5] = 1'b0;
        repeat (3) tick();
        wr(4'h4, 32'h20, 4'hF);
        rd_check("collide_cleared", 4'h4, 32'h0);

        // Masking
        wr(4'h8, 32'h0, 4'hF);
        src = 32'h0F;
        repeat (4) tick();
        check("mask_irq0", irq, 32'h0);
        rd_check("mask_active0", 4'hC, 32'h0);
        rd_check("mask_pending", 4'h4, 32'h0F);
        wr(4'h8, 32'h05, 4'hF);
        check("en_irq_at_ack", irq, 32'h0);
        tick();
        check("en_irq_after", irq, 32'h05);
        rd_check("en_pending_kept", 4'h4, 32'h0F);
        rd_check("en_active", 4'hC, 32'h05);
        wr(4'h8, 32'h0, 4'hF);
        tick();
        tick();
        check("disable_irq", irq, 32'h0);
        rd_check("disable_pending", 4'h4, 32'h0F);

        // Register-access table; line 5 rises in this step so it latches
        src = 32'hA5;
        repeat (4) tick();
        vt[0]  = '{1'b1, 4'h8, 32'hFFFF_FFFF, 4'b0001, 32'h0};
        vt[1]  = '{1'b0, 4'h8, 32'h0,         4'hF,    32'h0000_00FF};
        vt[2]  = '{1'b1, 4'h8, 32'h1234_5678, 4'b0100, 32'h0};
        vt[3]  = '{1'b0, 4'h8, 32'h0,         4'hF,    32'h0034_00FF};
        vt[4]  = '{1'b0, 4'h0, 32'h0,         4'hF,    32'h0000_00A5};
        vt[5]  = '{1'b1, 4'h0, 32'hFFFF_FFFF, 4'hF,    32'h0};
        vt[6]  = '{1'b0, 4'h0, 32'h0,         4'hF,    32'h0000_00A5};
        vt[7]  = '{1'b0, 4'h4, 32'h0,         4'hF,    32'h0000_00A5};
        vt[8]  = '{1'b0, 4'hC, 32'h0,         4'hF,    32'h0000_00A5};
        vt[9]  = '{1'b1, 4'hC, 32'h0,         4'hF,    32'h0};
        vt[10] = '{1'b0, 4'hC, 32'h0,         4'hF,    32'h0000_00A5};
        vt[11] = '{1'b1, 4'h4, 32'hFF,        4'hF,    32'h0};
        vt[12] = '{1'b0, 4'h4, 32'h0,         4'hF,    32'h0000_0085};
        vt[13] = '{1'b1, 4'h8, 32'h0,         4'b1110, 32'h0};
        for (int i = 0; i < 14; i++) begin
            if (vt[i].we) begin
                wr(vt[i].adr, vt[i].wdat, vt[i].sel);
            end else begin
                rd_check($sformatf("tbl%0d", i), vt[i].adr, vt[i].exp);
            end
        end
        rd_check("tbl_enable_end", 4'h8, 32'h0000_00FF);
        tick();
        check("tbl_irq", irq, 32'h85);

        // Reset asserted while a write is waiting for its ack
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = 1'b1;
        adr  = 4'h8;
        wdat = 32'h0000_FF00;
        sel  = 4'hF;
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_ack", {31'd0, ack}, 32'h0);
        check("midrst_irq", irq, 32'h0);
        check("midrst_dat", rdat, 32'h0);
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        rd_check("midrst_enable", 4'h8, 32'h0);
        repeat (4) tick();
        check("midrst_irq_after", irq, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
